outport_out_interface_serializer: RTL and testbench
===================================================

Name: outport_out_interface_serializer

Overview:
- Transmit-side counterpart of the input-port deserializer on a serial inter-router link.
- Accepts one parallel flit per valid/ready handshake from the output port and shifts it onto a 1-bit serial lane, LSB first, one bit per accepted beat.
- Emits first-bit and last-bit framing strobes so the far-end receiver can reset and close its bit-position counter.

Parameters:
- flit_size, 8, flit width in bits (>=1).
- floorplusone_log2_flit_size, 4, bit-counter width, floor(log2(flit_size))+1; must be able to hold the value flit_size.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- flit_in  input  flit_size  parallel flit from output port.
- flit_valid  input  1  flit_in holds a flit.
- flit_ready  output  1  serializer accepts flit_in this cycle.
- flush  input  1  synchronous abort of the flit in flight.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  link/receiver accepts ser_out this cycle.
- ser_first  output  1  current bit is bit 0 of a flit.
- ser_last  output  1  current bit is bit flit_size-1 of a flit.
- bit_cnt  output  floorplusone_log2_flit_size  index of the bit currently presented.
- busy  output  1  a flit is being serialized (state SHIFT).

Behaviour:
- Internal state:
  - FSM with states IDLE and SHIFT.
  - shift register shreg, width flit_size.
  - counter cnt, width floorplusone_log2_flit_size; bit_cnt = cnt.
- Reset (async, rst high): state=IDLE, shreg=0, cnt=0. Outputs while in reset: ser_valid=0, ser_out=0, ser_first=0, ser_last=0, busy=0, flit_ready=0. Leaving reset resumes normal IDLE behaviour on the next edge.
- IDLE:
  - flit_ready=1, ser_valid=0, ser_out=0.
  - On posedge with flit_valid=1 and flush=0: shreg<=flit_in, cnt<=0, state<=SHIFT.
  - Latency: the first serial bit is valid in the cycle after acceptance.
- SHIFT outputs:
  - ser_valid=1, ser_out=shreg[0], busy=1.
  - ser_first=(cnt==0); ser_last=(cnt==flit_size-1).
- SHIFT with ser_ready=0: hold shreg, cnt, ser_out and the framing strobes stable.
- SHIFT with ser_ready=1 and cnt<flit_size-1: shreg<=shreg>>1 (zero fill), cnt<=cnt+1.
- SHIFT with ser_ready=1 and cnt==flit_size-1 (last beat):
  - flit_ready=1 combinationally in this cycle.
  - If flit_valid=1: load the new flit, cnt<=0, stay in SHIFT. Back-to-back flits have no bubble.
  - Otherwise: state<=IDLE, cnt<=0, shreg<=0.
- flit_ready is 0 at all other SHIFT cycles.
- flush: highest priority after rst. On a posedge with flush=1: state<=IDLE, cnt<=0, shreg<=0. flit_ready=0 while flush=1, so no flit is accepted that cycle.
- flit_size=1: ser_first and ser_last are both high on the single beat.
- cnt never exceeds flit_size-1 and never wraps.
- rst asserted mid-flit: the flit is discarded immediately; no partial-flit completion.

Test Plan:
- Reset while SHIFT at cnt=3 -> same cycle: ser_valid=0, busy=0, bit_cnt=0; after release flit_ready=1.
- Single flit: flit_in=8'hA5, flit_valid one cycle, ser_ready=1 held -> ser_valid from next cycle for exactly 8 cycles; ser_out sequence 1,0,1,0,0,1,0,1; ser_first on beat 0 only, ser_last on beat 7 only; then IDLE with ser_valid=0.
- Backpressure: flit 8'h3C, ser_ready low on beats 2 and 5 for 3 cycles each -> ser_out and bit_cnt frozen during stalls; the correct bit stream still completes in 14 cycles.
- Back-to-back: 8'hFF then 8'h00, with flit_valid high at the last beat -> flit_ready high in that cycle; 16 contiguous valid beats (eight 1s, eight 0s); ser_first on beats 0 and 8.
- Flush at cnt=4 -> next cycle ser_valid=0, bit_cnt=0; a following flit 8'h81 serializes cleanly starting with ser_first=1.
- flit_size=1 build: flit 1'b1 -> one beat with ser_out=1, ser_first=ser_last=1; flit_ready=1 in that same beat.

Source files
------------

// File: rtl/outport_out_interface_serializer.sv
// Transmit side of a serial inter-router link: takes one parallel flit per
// handshake and shifts it out LSB first with first/last framing strobes.
module outport_out_interface_serializer #(
   parameter int flit_size                   = 8,
   parameter int floorplusone_log2_flit_size = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [flit_size-1:0]                   flit_in,
   input  logic                                   flit_valid,
   output logic                                   flit_ready,
   input  logic                                   flush,
   output logic                                   ser_out,
   output logic                                   ser_valid,
   input  logic                                   ser_ready,
   output logic                                   ser_first,
   output logic                                   ser_last,
   output logic [floorplusone_log2_flit_size-1:0] bit_cnt,
   output logic                                   busy
);

   localparam int CNT_W = floorplusone_log2_flit_size;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(flit_size - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state_q, state_d;
   logic [flit_size-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      flit_ready = 1'b0;
      ser_valid  = 1'b0;
      ser_out    = 1'b0;
      ser_first  = 1'b0;
      ser_last   = 1'b0;
      busy       = 1'b0;

      case (state_q)
         IDLE: begin
            flit_ready = ~flush & ~rst;
            if (flit_valid && !flush) begin
               shreg_d = flit_in;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = shreg_q[0];
            busy      = 1'b1;
            ser_first = (cnt_q == '0);
            ser_last  = (cnt_q == LAST_CNT);
            if (ser_ready) begin
               if (cnt_q == LAST_CNT) begin
                  // Accepting on the last beat keeps consecutive flits bubble-free.
                  flit_ready = ~flush & ~rst;
                  cnt_d      = '0;
                  if (flit_valid) begin
                     shreg_d = flit_in;
                  end else begin
                     shreg_d = '0;
                     state_d = IDLE;
                  end
               end else begin
                  shreg_d = shreg_q >> 1;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over any load or shift decided above.
      if (flush) begin
         state_d = IDLE;
         shreg_d = '0;
         cnt_d   = '0;
      end
   end

   assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_outport_out_interface_serializer.sv
// Scoreboard bench for the flit serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares each beat the link consumes.
module tb_outport_out_interface_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] flit_in;
   logic       flit_valid;
   logic       flit_ready;
   logic       flush;
   logic       ser_out;
   logic       ser_valid;
   logic       ser_ready;
   logic       ser_first;
   logic       ser_last;
   logic [3:0] bit_cnt;
   logic       busy;

   logic [0:0] flit_in1;
   logic       flit_valid1, flit_ready1, flush1;
   logic       ser_out1, ser_valid1, ser_ready1, ser_first1, ser_last1, busy1;
   logic [0:0] bit_cnt1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       out;
      logic       first;
      logic       last;
      logic [3:0] cnt;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   outport_out_interface_serializer #(.flit_size(8), .floorplusone_log2_flit_size(4)) dut (
      .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
      .flit_ready(flit_ready), .flush(flush), .ser_out(ser_out), .ser_valid(ser_valid),
      .ser_ready(ser_ready), .ser_first(ser_first), .ser_last(ser_last),
      .bit_cnt(bit_cnt), .busy(busy)
   );

   outport_out_interface_serializer #(.flit_size(1), .floorplusone_log2_flit_size(1)) dut1 (
      .clk(clk), .rst(rst), .flit_in(flit_in1), .flit_valid(flit_valid1),
      .flit_ready(flit_ready1), .flush(flush1), .ser_out(ser_out1), .ser_valid(ser_valid1),
      .ser_ready(ser_ready1), .ser_first(ser_first1), .ser_last(ser_last1),
      .bit_cnt(bit_cnt1), .busy(busy1)
   );

   // Monitor: a stalled beat is compared without popping, so frozen outputs are checked too.
   always @(negedge clk) begin
      if (!rst) begin
         if (ser_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got out=%0b cnt=%0d, required no valid beat", ser_out, bit_cnt);
            end else begin
               if ({ser_out, ser_first, ser_last, bit_cnt, busy} !== {exp_q[0], 1'b1}) begin
                  errors++;
                  $display("FAIL beat: got out=%0b first=%0b last=%0b cnt=%0d busy=%0b, required out=%0b first=%0b last=%0b cnt=%0d busy=1",
                           ser_out, ser_first, ser_last, bit_cnt, busy,
                           exp_q[0].out, exp_q[0].first, exp_q[0].last, exp_q[0].cnt);
               end
               if (ser_ready) void'(exp_q.pop_front());
            end
         end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL bubble: got ser_valid=0, required ser_valid=1 (%0d beats pending)", exp_q.size());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   // Pushes the expected beats after the accepting edge, so the queue is non-empty exactly while beats are due.
   task automatic send(input logic [7:0] d, output int waits);
      bit acc;
      acc = 1'b0;
      waits = 0;
      flit_in = d;
      flit_valid = 1'b1;
      while (!acc && waits < 50) begin
         @(negedge clk);
         if (flit_ready) acc = 1'b1;
         else waits++;
      end
      tick();
      flit_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: got flit_ready=0 for %0d cycles, required acceptance", waits);
      end else begin
         for (int k = 0; k < 8; k++) begin
            exp_q.push_back('{out: d[k], first: (k == 0), last: (k == 7), cnt: 4'(k)});
         end
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      check(name, {10'b0, ser_valid, busy, bit_cnt}, 16'h0);
      check({name, "_ready"}, {15'b0, flit_ready}, 16'h1);
      check({name, "_drained"}, 16'(exp_q.size()), 16'h0);
      tick();
   endtask

   initial begin
      int w;
      logic [13:0] pat;
      rst = 1'b1;
      flit_in = '0; flit_valid = 1'b0; flush = 1'b0; ser_ready = 1'b1;
      flit_in1 = '0; flit_valid1 = 1'b0; flush1 = 1'b0; ser_ready1 = 1'b1;

      #2;
      check("reset_outs", {9'b0, ser_valid, ser_out, ser_first, ser_last, busy, flit_ready, 1'b0},
            16'h0);
      check("reset_cnt", {12'b0, bit_cnt}, 16'h0);
      tick();
      tick();
      rst = 1'b0;
      check_idle("post_reset");

      // Single flit with continuous ser_ready.
      send(8'hA5, w);
      repeat (8) tick();
      check_idle("after_A5");

      // Backpressure: three-cycle stalls at beats 2 and 5.
      pat = 14'b11100011100011;
      send(8'h3C, w);
      for (int i = 0; i < 14; i++) begin
         ser_ready = pat[i];
         tick();
      end
      ser_ready = 1'b1;
      check_idle("after_3C");

      // Back-to-back flits; the second is accepted on the first's last beat.
      send(8'hFF, w);
      send(8'h00, w);
      check("b2b_accept_wait", 16'(w), 16'd7);
      repeat (8) tick();
      check_idle("after_b2b");

      // Flush while beat 4 is presented.
      send(8'hC3, w);
      repeat (4) tick();
      ser_ready = 1'b0;
      flush = 1'b1;
      #1;
      check("flush_ready", {15'b0, flit_ready}, 16'h0);
      tick();
      flush = 1'b0;
      ser_ready = 1'b1;
      exp_q.delete();
      check_idle("after_flush");
      send(8'h81, w);
      repeat (8) tick();
      check_idle("after_81");

      // Asynchronous reset in the middle of a flit.
      send(8'h96, w);
      repeat (3) tick();
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_mid_flit", {11'b0, ser_valid, busy, bit_cnt}, 16'h0);
      check("rst_mid_ready", {15'b0, flit_ready}, 16'h0);
      tick();
      rst = 1'b0;
      check_idle("after_rst");

      // Single-bit flit instance.
      @(negedge clk);
      check("fs1_idle", {13'b0, ser_valid1, flit_ready1, busy1}, 16'h2);
      flit_in1 = 1'b1;
      flit_valid1 = 1'b1;
      tick();
      @(negedge clk);
      check("fs1_beat", {10'b0, ser_valid1, ser_out1, ser_first1, ser_last1, flit_ready1, busy1},
            16'h3F);
      check("fs1_cnt", {15'b0, bit_cnt1}, 16'h0);
      flit_valid1 = 1'b0;
      tick();
      @(negedge clk);
      check("fs1_done", {13'b0, ser_valid1, flit_ready1, busy1}, 16'h2);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
